syst_apb_stream_if: RTL

- Parametrised APB slave front-end for an NxN systolic array.
- Holds N weight-row registers and buffers input activations in an input FIFO, which streams to the array via valid/ready.
- Collects array results in an output FIFO, drained by APB reads.
- Over the previous single-depth interface it adds FIFO depth, wait-state back-pressure, a timeout with slave error, status/control registers and an interrupt.

---
 rtl/syst_apb_stream_if.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/syst_apb_stream_if.sv
// APB slave front-end for an NxN systolic array: weight-row registers,
// an input activation FIFO streamed to the array, and an output result FIFO drained over APB.
module syst_apb_stream_if #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic              p_clk_i,
    input  logic              p_rst_i,
    input  logic [31:0]       p_adr_i,
    input  logic [31:0]       p_dat_i,
    output logic [31:0]       p_dat_o,
    input  logic              p_sel_i,
    input  logic              p_enable_i,
    input  logic              p_we_i,
    output logic              p_ready,
    output logic              p_slverr,
    output logic [N*N*DW-1:0] w_o,
    output logic [N*DW-1:0]   a_dat_o,
    output logic              a_vld_o,
    input  logic              a_rdy_i,
    input  logic [31:0]       r_dat_i,
    input  logic              r_vld_i,
    output logic              r_rdy_o,
    output logic              irq_o
);
    localparam int LW  = N * DW;
    localparam int IPW = $clog2(IN_DEPTH);
    localparam int OPW = $clog2(OUT_DEPTH);
    localparam int TOW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic [LW-1:0]  r_in_mem  [IN_DEPTH];
    logic [IPW-1:0] r_in_wp, r_in_rp;
    logic [IPW:0]   r_in_cnt;
    logic [31:0]    r_out_mem [OUT_DEPTH];
    logic [OPW-1:0] r_out_wp, r_out_rp;
    logic [OPW:0]   r_out_cnt;
    logic [LW-1:0]  r_w [N];
    logic           r_en, r_irq_en;
    logic [TOW-1:0] r_to_cnt;

    logic [7:0]  w_adr;
    int unsigned w_widx;
    logic        w_is_data, w_is_res, w_is_wgt, w_is_stat, w_is_ctrl, w_adr_ok;
    logic        w_in_empty, w_in_full, w_out_empty, w_out_full;
    logic        w_stall, w_tmo, w_commit, w_err, w_ok;
    logic        w_in_push, w_in_pop, w_out_push, w_out_pop, w_wgt_wr, w_ctrl_wr, w_clear;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Upper address bits and unused data lanes are ignored by design
    assign w_unused = ^{p_adr_i[31:8], p_dat_i};

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (p_sel_i && p_enable_i) w_state_nxt = S_ACCESS;
            S_ACCESS: if (w_commit) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_adr       = p_adr_i[7:0];
        w_widx      = 32'(w_adr[7:2]) - 32'd2;
        w_is_data   = (w_adr == 8'h00);
        w_is_res    = (w_adr == 8'h04);
        w_is_stat   = (w_adr == 8'h40);
        w_is_ctrl   = (w_adr == 8'h44);
        w_is_wgt    = (w_adr >= 8'h08) && (w_adr < 8'(8 + 4 * N)) && (w_adr[1:0] == 2'b00);
        w_adr_ok    = w_is_data || w_is_res || w_is_stat || w_is_ctrl || w_is_wgt;
        w_in_empty  = (r_in_cnt == '0);
        w_in_full   = (r_in_cnt == (IPW + 1)'(IN_DEPTH));
        w_out_empty = (r_out_cnt == '0);
        w_out_full  = (r_out_cnt == (OPW + 1)'(OUT_DEPTH));
        // Stalls look only at registered counts, so a same-cycle pop never unblocks a full push
        w_stall     = (r_state == S_ACCESS) &&
                      ((w_is_data && p_we_i && w_in_full) || (w_is_res && !p_we_i && w_out_empty));
        w_tmo       = w_stall && (r_to_cnt == TOW'(TIMEOUT - 1));
        w_commit    = (r_state == S_ACCESS) && (!w_stall || w_tmo);
        w_err       = w_tmo || !w_adr_ok;
        w_ok        = w_commit && !w_err;
        w_in_push   = w_ok && w_is_data && p_we_i;
        w_out_pop   = w_ok && w_is_res && !p_we_i;
        w_wgt_wr    = w_ok && w_is_wgt && p_we_i;
        w_ctrl_wr   = w_ok && w_is_ctrl && p_we_i;
        w_clear     = w_ctrl_wr && p_dat_i[2];
        w_rdata     = '0;
        if (!p_we_i && !w_err) begin
            if (w_is_res)  w_rdata = r_out_mem[r_out_rp];
            if (w_is_stat) w_rdata = {8'd0, 8'(r_out_cnt), 8'(r_in_cnt), 4'd0,
                                      w_out_full, w_out_empty, w_in_full, w_in_empty};
            if (w_is_ctrl) w_rdata = {30'd0, r_irq_en, r_en};
            if (w_is_wgt) begin
                for (int unsigned i = 0; i < N; i++)
                    if (w_widx == i) w_rdata = 32'(r_w[i]);
            end
        end
    end

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            p_ready  <= 1'b0;
            p_slverr <= 1'b0;
            p_dat_o  <= '0;
            r_to_cnt <= '0;
        end else begin
            p_ready  <= w_commit;
            p_slverr <= w_commit && w_err;
            p_dat_o  <= w_commit ? w_rdata : '0;
            if (w_commit)     r_to_cnt <= '0;
            else if (w_stall) r_to_cnt <= r_to_cnt + TOW'(1);
        end
    end

    assign a_vld_o  = !w_in_empty && r_en;
    assign a_dat_o  = r_in_mem[r_in_rp];
    assign w_in_pop = a_vld_o && a_rdy_i;

    always_ff @(posedge p_clk_i) begin
        if (w_in_push) r_in_mem[r_in_wp] <= p_dat_i[LW-1:0];
    end

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i || w_clear) begin
            r_in_wp  <= '0;
            r_in_rp  <= '0;
            r_in_cnt <= '0;
        end else begin
            if (w_in_push) r_in_wp <= r_in_wp + IPW'(1);
            if (w_in_pop)  r_in_rp <= r_in_rp + IPW'(1);
            case ({w_in_push, w_in_pop})
                2'b10:   r_in_cnt <= r_in_cnt + (IPW + 1)'(1);
                2'b01:   r_in_cnt <= r_in_cnt - (IPW + 1)'(1);
                default: r_in_cnt <= r_in_cnt;
            endcase
        end
    end

    assign r_rdy_o    = (r_out_cnt < (OPW + 1)'(OUT_DEPTH));
    assign w_out_push = r_vld_i && r_rdy_o;

    always_ff @(posedge p_clk_i) begin
        if (w_out_push) r_out_mem[r_out_wp] <= r_dat_i;
    end

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i || w_clear) begin
            r_out_wp  <= '0;
            r_out_rp  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_out_push) r_out_wp <= r_out_wp + OPW'(1);
            if (w_out_pop)  r_out_rp <= r_out_rp + OPW'(1);
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + (OPW + 1)'(1);
                2'b01:   r_out_cnt <= r_out_cnt - (OPW + 1)'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    always_ff @(posedge p_clk_i) begin
        if (p_rst_i) begin
            r_en     <= 1'b1;
            r_irq_en <= 1'b0;
            irq_o    <= 1'b0;
            for (int unsigned i = 0; i < N; i++) r_w[i] <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= p_dat_i[0];
                r_irq_en <= p_dat_i[1];
            end
            irq_o <= r_irq_en && !w_out_empty;
            for (int unsigned i = 0; i < N; i++)
                if (w_wgt_wr && w_widx == i) r_w[i] <= p_dat_i[LW-1:0];
        end
    end

    always_comb begin
        w_o = '0;
        for (int unsigned i = 0; i < N; i++) w_o[i*LW +: LW] = r_w[i];
    end
endmodule
